// File: rtl/sirv_otp_pkg.sv
// Shared definitions for the OTP controller: FSM encodings, default timing
// parameters and the port identifiers used by the arbiter and response mux.
package sirv_otp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_PGM  = 2'd2,
    ST_RSP  = 2'd3
  } state_t;

  localparam int DEF_RD_LAT  = 2;
  localparam int DEF_PGM_CYC = 16;

  localparam logic PORT_F = 1'b0;
  localparam logic PORT_I = 1'b1;

endpackage

// File: rtl/sirv_otp_rr_arb.sv
// Two-way round-robin arbiter between the fetch and register ports; the
// 'last' flop remembers which port won the most recent accepted command.
module sirv_otp_rr_arb
  import sirv_otp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_grant
);

  logic r_last;

  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      // On a tie the port that did not win last time goes first.
      2'b11:   o_grant = (r_last == PORT_I) ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= PORT_I;
    end else if (i_accept) begin
      r_last <= o_grant[PORT_I];
    end
  end

endmodule

// File: rtl/sirv_otp_ctrl.sv
// OTP macro controller: arbitrates two ICB ports onto one macro, sequences
// fixed-latency reads and timed program pulses, and routes the response back.
module sirv_otp_ctrl
  import sirv_otp_pkg::*;
#(
  parameter int OTP_AW  = 10,
  parameter int RD_LAT  = DEF_RD_LAT,
  parameter int PGM_CYC = DEF_PGM_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_icb_cmd_valid,
  output logic              f_icb_cmd_ready,
  input  logic [31:0]       f_icb_cmd_addr,
  input  logic              f_icb_cmd_read,
  input  logic [31:0]       f_icb_cmd_wdata,
  output logic              f_icb_rsp_valid,
  input  logic              f_icb_rsp_ready,
  output logic [31:0]       f_icb_rsp_rdata,
  output logic              f_icb_rsp_err,
  input  logic              i_icb_cmd_valid,
  output logic              i_icb_cmd_ready,
  input  logic [31:0]       i_icb_cmd_addr,
  input  logic              i_icb_cmd_read,
  input  logic [31:0]       i_icb_cmd_wdata,
  output logic              i_icb_rsp_valid,
  input  logic              i_icb_rsp_ready,
  output logic [31:0]       i_icb_rsp_rdata,
  output logic              i_icb_rsp_err,
  output logic              otp_ce,
  output logic              otp_pgm,
  output logic [OTP_AW-1:0] otp_addr,
  output logic [31:0]       otp_wdata,
  input  logic [31:0]       otp_rdata
);

  localparam int MAXC = (RD_LAT > PGM_CYC) ? RD_LAT : PGM_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic                r_owner;
  logic                r_ce;
  logic                r_pgm;
  logic [OTP_AW-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;
  logic                r_err;
  logic                r_rspValid;

  logic [1:0]          w_req;
  logic [1:0]          w_grant;
  logic                w_idle;
  logic                w_accept;
  logic                w_selI;
  logic [31:0]         w_cmdAddr;
  logic                w_cmdRead;
  logic                w_rspReady;
  logic                w_unused;

  assign w_req      = {i_icb_cmd_valid, f_icb_cmd_valid};
  assign w_idle     = (r_state == ST_IDLE);
  assign w_accept   = w_idle & (|w_grant);
  assign w_selI     = w_grant[PORT_I];
  assign w_cmdAddr  = w_selI ? i_icb_cmd_addr : f_icb_cmd_addr;
  assign w_cmdRead  = w_selI ? i_icb_cmd_read : f_icb_cmd_read;
  assign w_rspReady = (r_owner == PORT_I) ? i_icb_rsp_ready : f_icb_rsp_ready;

  // Byte offset and bits above the macro range are decoded upstream.
  assign w_unused = ^{f_icb_cmd_wdata, w_cmdAddr[31:OTP_AW+2], w_cmdAddr[1:0]};

  sirv_otp_rr_arb u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_req    (w_req),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  assign f_icb_cmd_ready = w_idle & w_grant[PORT_F];
  assign i_icb_cmd_ready = w_idle & w_grant[PORT_I];

  assign f_icb_rsp_valid = r_rspValid & (r_owner == PORT_F);
  assign i_icb_rsp_valid = r_rspValid & (r_owner == PORT_I);
  assign f_icb_rsp_rdata = f_icb_rsp_valid ? r_rdata : 32'h0;
  assign i_icb_rsp_rdata = i_icb_rsp_valid ? r_rdata : 32'h0;
  assign f_icb_rsp_err   = f_icb_rsp_valid & r_err;
  assign i_icb_rsp_err   = i_icb_rsp_valid & r_err;

  assign otp_ce    = r_ce;
  assign otp_pgm   = r_pgm;
  assign otp_addr  = r_addr;
  assign otp_wdata = r_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_owner    <= PORT_F;
      r_ce       <= 1'b0;
      r_pgm      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 32'h0;
      r_rdata    <= 32'h0;
      r_err      <= 1'b0;
      r_rspValid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_owner <= w_selI;
            if (w_cmdRead) begin
              r_state <= ST_READ;
              r_cnt   <= CW'(RD_LAT - 1);
              r_ce    <= 1'b1;
              r_addr  <= w_cmdAddr[OTP_AW+1:2];
            end else if (w_selI) begin
              r_state <= ST_PGM;
              r_cnt   <= CW'(PGM_CYC - 1);
              r_ce    <= 1'b1;
              r_pgm   <= 1'b1;
              r_addr  <= w_cmdAddr[OTP_AW+1:2];
              r_wdata <= i_icb_cmd_wdata;
            end else begin
              // The fetch port may not program; answer with an error at once.
              r_state    <= ST_RSP;
              r_rdata    <= 32'h0;
              r_err      <= 1'b1;
              r_rspValid <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (r_cnt == '0) begin
            r_state    <= ST_RSP;
            r_rdata    <= otp_rdata;
            r_err      <= 1'b0;
            r_rspValid <= 1'b1;
            r_ce       <= 1'b0;
            r_addr     <= '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_PGM: begin
          if (r_cnt == '0) begin
            r_state    <= ST_RSP;
            r_rdata    <= 32'h0;
            r_err      <= 1'b0;
            r_rspValid <= 1'b1;
            r_ce       <= 1'b0;
            r_pgm      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'h0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RSP: begin
          if (w_rspReady) begin
            r_state    <= ST_IDLE;
            r_rspValid <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sirv_otp_ctrl.sv
// Self-checking bench for sirv_otp_ctrl with a behavioural OTP macro model
// and a queue of expected responses filled at command handshake.
module tb_sirv_otp_ctrl;
  import sirv_otp_pkg::*;

  localparam int AW  = 10;
  localparam int RDL = 2;
  localparam int PGC = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic f_cmd_valid = 0, f_cmd_ready, f_cmd_read = 0;
  logic [31:0] f_cmd_addr = 0, f_cmd_wdata = 0;
  logic f_rsp_valid, f_rsp_ready = 1, f_rsp_err;
  logic [31:0] f_rsp_rdata;
  logic i_cmd_valid = 0, i_cmd_ready, i_cmd_read = 0;
  logic [31:0] i_cmd_addr = 0, i_cmd_wdata = 0;
  logic i_rsp_valid, i_rsp_ready = 1, i_rsp_err;
  logic [31:0] i_rsp_rdata;
  logic otp_ce, otp_pgm;
  logic [AW-1:0] otp_addr;
  logic [31:0] otp_wdata, otp_rdata;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ceRun = 0;
  logic [31:0] mem [0:(1<<AW)-1];

  sirv_otp_ctrl #(.OTP_AW(AW), .RD_LAT(RDL), .PGM_CYC(PGC)) dut (
    .clk(clk), .rst(rst),
    .f_icb_cmd_valid(f_cmd_valid), .f_icb_cmd_ready(f_cmd_ready),
    .f_icb_cmd_addr(f_cmd_addr), .f_icb_cmd_read(f_cmd_read),
    .f_icb_cmd_wdata(f_cmd_wdata),
    .f_icb_rsp_valid(f_rsp_valid), .f_icb_rsp_ready(f_rsp_ready),
    .f_icb_rsp_rdata(f_rsp_rdata), .f_icb_rsp_err(f_rsp_err),
    .i_icb_cmd_valid(i_cmd_valid), .i_icb_cmd_ready(i_cmd_ready),
    .i_icb_cmd_addr(i_cmd_addr), .i_icb_cmd_read(i_cmd_read),
    .i_icb_cmd_wdata(i_cmd_wdata),
    .i_icb_rsp_valid(i_rsp_valid), .i_icb_rsp_ready(i_rsp_ready),
    .i_icb_rsp_rdata(i_rsp_rdata), .i_icb_rsp_err(i_rsp_err),
    .otp_ce(otp_ce), .otp_pgm(otp_pgm), .otp_addr(otp_addr),
    .otp_wdata(otp_wdata), .otp_rdata(otp_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Macro model: data is only valid during the last read-enable cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) ceRun <= 0;
    else     ceRun <= otp_ce ? ceRun + 1 : 0;
  end
  assign otp_rdata = (otp_ce && !otp_pgm && ceRun == RDL - 1) ? mem[otp_addr] : 32'hBAD0_BAD0;

  task automatic doReset();
    rst = 1'b1;
    f_cmd_valid = 0; i_cmd_valid = 0;
    f_rsp_ready = 1; i_rsp_ready = 1;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic sendCmd(input logic port, input logic [31:0] addr, input logic rd,
                         input logic [31:0] wd, input exp_t e, output int hs, output bit ok);
    ok = 0;
    hs = cyc;
    if (port == PORT_F) begin
      f_cmd_valid = 1; f_cmd_addr = addr; f_cmd_read = rd; f_cmd_wdata = wd;
    end else begin
      i_cmd_valid = 1; i_cmd_addr = addr; i_cmd_read = rd; i_cmd_wdata = wd;
    end
    for (int k = 0; k < 50 && !ok; k++) begin
      #1;
      if ((port == PORT_F) ? f_cmd_ready : i_cmd_ready) begin
        ok = 1;
        hs = cyc;
        sb.push_back(e);
      end else begin
        @(negedge clk);
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL cmd_accept port=%0d: got no cmd_ready, required cmd_ready=1", port);
    end else begin
      @(posedge clk);
      #1;
    end
    if (port == PORT_F) f_cmd_valid = 0; else i_cmd_valid = 0;
    @(negedge clk);
  endtask

  // Waits for the response on 'port', tracking macro activity on the way.
  task automatic waitRsp(input logic port, input int hs, input int expCe, input int expPgm,
                         input logic [AW-1:0] expAddr, input logic [31:0] expWd, input int stall);
    exp_t e;
    int ceN = 0, pgmN = 0, lat = 0;
    bit seen = 0, addrBad = 0, wrongOwner = 0;
    logic myV, othV, myErr;
    logic [31:0] myData;
    if (port == PORT_F) f_rsp_ready = (stall == 0); else i_rsp_ready = (stall == 0);
    for (int k = 0; k < 200 && !seen; k++) begin
      myV  = (port == PORT_F) ? f_rsp_valid : i_rsp_valid;
      othV = (port == PORT_F) ? i_rsp_valid : f_rsp_valid;
      if (othV) wrongOwner = 1;
      if (myV) begin
        seen = 1;
      end else begin
        if (otp_ce) begin
          ceN++;
          if (otp_addr !== expAddr) addrBad = 1;
        end
        if (otp_pgm) begin
          pgmN++;
          if (otp_wdata !== expWd) addrBad = 1;
        end
        @(negedge clk);
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("[TB] FAIL rsp_timeout port=%0d: rsp_valid=0, required 1", port);
      return;
    end
    lat    = cyc - hs;
    myData = (port == PORT_F) ? f_rsp_rdata : i_rsp_rdata;
    myErr  = (port == PORT_F) ? f_rsp_err : i_rsp_err;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("[TB] FAIL rsp_unexpected port=%0d: response with empty scoreboard", port);
      return;
    end
    e = sb.pop_front();
    total++; if (port !== e.port) begin bad++; $display("[TB] FAIL rsp_owner got=%0d exp=%0d", port, e.port); end
    total++; if (lat !== e.lat) begin bad++; $display("[TB] FAIL rsp_latency got=%0d exp=%0d", lat, e.lat); end
    total++; if (myData !== e.rdata) begin bad++; $display("[TB] FAIL rsp_rdata got=%h exp=%h", myData, e.rdata); end
    total++; if (myErr !== e.err) begin bad++; $display("[TB] FAIL rsp_err got=%b exp=%b", myErr, e.err); end
    total++; if (ceN !== expCe) begin bad++; $display("[TB] FAIL ce_cycles got=%0d exp=%0d", ceN, expCe); end
    total++; if (pgmN !== expPgm) begin bad++; $display("[TB] FAIL pgm_cycles got=%0d exp=%0d", pgmN, expPgm); end
    total++; if (addrBad) begin bad++; $display("[TB] FAIL macro_addr_wdata got=unstable exp addr=%h wdata=%h", expAddr, expWd); end
    total++; if (wrongOwner) begin bad++; $display("[TB] FAIL other_rsp_valid got=1 exp=0 (port %0d)", port); end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      myV = (port == PORT_F) ? f_rsp_valid : i_rsp_valid;
      total++;
      if ({myV, ((port == PORT_F) ? f_rsp_rdata : i_rsp_rdata), ((port == PORT_F) ? f_rsp_err : i_rsp_err),
           f_cmd_ready, i_cmd_ready} !== {1'b1, myData, myErr, 1'b0, 1'b0}) begin
        bad++;
        $display("[TB] FAIL rsp_stall_hold cycle=%0d got v=%b d=%h rdyF=%b rdyI=%b exp v=1 d=%h rdy=0",
                 s, myV, (port == PORT_F) ? f_rsp_rdata : i_rsp_rdata, f_cmd_ready, i_cmd_ready, myData);
      end
    end
    if (port == PORT_F) f_rsp_ready = 1; else i_rsp_ready = 1;
    #1;
    total++;
    if ({f_cmd_ready, i_cmd_ready} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL rsp_cycle_cmd_ready got=%b%b exp=00", f_cmd_ready, i_cmd_ready);
    end
    @(posedge clk);
    @(negedge clk);
    myV = (port == PORT_F) ? f_rsp_valid : i_rsp_valid;
    total++;
    if (myV !== 1'b0) begin bad++; $display("[TB] FAIL rsp_release got valid=%b exp=0", myV); end
  endtask

  task automatic test_reset();
    total++;
    if ({otp_ce, otp_pgm, otp_addr, otp_wdata, f_rsp_valid, i_rsp_valid} !== '0) begin
      bad++; $display("[TB] FAIL reset_during got nonzero outputs exp all 0");
    end
    doReset();
    total++;
    if ({otp_ce, otp_pgm, otp_addr, otp_wdata} !== '0) begin
      bad++; $display("[TB] FAIL reset_macro got ce=%b pgm=%b addr=%h wd=%h exp 0", otp_ce, otp_pgm, otp_addr, otp_wdata);
    end
    total++;
    if ({f_rsp_valid, i_rsp_valid, f_rsp_err, i_rsp_err, f_rsp_rdata, i_rsp_rdata} !== '0) begin
      bad++; $display("[TB] FAIL reset_rsp got fv=%b iv=%b exp 0", f_rsp_valid, i_rsp_valid);
    end
    total++;
    if ({f_cmd_ready, i_cmd_ready} !== 2'b00) begin
      bad++; $display("[TB] FAIL reset_cmd_ready got=%b%b exp=00", f_cmd_ready, i_cmd_ready);
    end
  endtask

  task automatic test_read_f();
    int hs; bit ok;
    sendCmd(PORT_F, 32'h0000_0010, 1'b1, 32'h0, '{PORT_F, 32'hDEAD_BEEF, 1'b0, RDL + 1}, hs, ok);
    if (ok) waitRsp(PORT_F, hs, RDL, 0, 10'd4, 32'h0, 0);
  endtask

  task automatic test_pgm_i();
    int hs; bit ok;
    sendCmd(PORT_I, 32'h0000_0020, 1'b0, 32'h1234_5678, '{PORT_I, 32'h0, 1'b0, PGC + 1}, hs, ok);
    if (ok) waitRsp(PORT_I, hs, PGC, PGC, 10'd8, 32'h1234_5678, 0);
  endtask

  task automatic test_write_f();
    int hs; bit ok;
    sendCmd(PORT_F, 32'h0000_0030, 1'b0, 32'hFFFF_0000, '{PORT_F, 32'h0, 1'b1, 1}, hs, ok);
    if (ok) waitRsp(PORT_F, hs, 0, 0, 10'd0, 32'h0, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] fA, iA, a;
    logic expP, actP;
    bit got;
    int hs;
    doReset();
    fA = 32'h100; iA = 32'h200;
    f_cmd_valid = 1; f_cmd_read = 1; f_cmd_addr = fA;
    i_cmd_valid = 1; i_cmd_read = 1; i_cmd_addr = iA;
    for (int n = 0; n < 4; n++) begin
      expP = (n % 2 == 1) ? PORT_I : PORT_F;
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
        #1;
        if (f_cmd_ready || i_cmd_ready) got = 1; else @(negedge clk);
      end
      total++;
      if (!got || {f_cmd_ready, i_cmd_ready} !== ((expP == PORT_F) ? 2'b10 : 2'b01)) begin
        bad++;
        $display("[TB] FAIL rr_grant n=%0d got rdyF=%b rdyI=%b exp port=%0d", n, f_cmd_ready, i_cmd_ready, expP);
      end
      if (!got) break;
      actP = i_cmd_ready ? PORT_I : PORT_F;
      a = (actP == PORT_I) ? iA : fA;
      sb.push_back('{actP, mem[a[AW+1:2]], 1'b0, RDL + 1});
      hs = cyc;
      @(posedge clk);
      #1;
      if (actP == PORT_I) begin iA = iA + 8; i_cmd_addr = iA; end
      else begin fA = fA + 8; f_cmd_addr = fA; end
      @(negedge clk);
      waitRsp(actP, hs, RDL, 0, a[AW+1:2], 32'h0, 0);
    end
    f_cmd_valid = 0; i_cmd_valid = 0;
    @(negedge clk);
  endtask

  task automatic test_stall();
    int hs; bit ok;
    i_cmd_valid = 1; i_cmd_read = 1; i_cmd_addr = 32'h80;
    sendCmd(PORT_F, 32'h0000_0044, 1'b1, 32'h0, '{PORT_F, mem[17], 1'b0, RDL + 1}, hs, ok);
    if (ok) waitRsp(PORT_F, hs, RDL, 0, 10'd17, 32'h0, 10);
    sendCmd(PORT_I, 32'h80, 1'b1, 32'h0, '{PORT_I, mem[32], 1'b0, RDL + 1}, hs, ok);
    if (ok) waitRsp(PORT_I, hs, RDL, 0, 10'd32, 32'h0, 0);
  endtask

  task automatic test_reset_mid();
    int hs; bit ok;
    sendCmd(PORT_I, 32'h0000_0030, 1'b0, 32'hA5A5_5A5A, '{PORT_I, 32'h0, 1'b0, PGC + 1}, hs, ok);
    repeat (4) @(negedge clk);
    total++;
    if ({otp_ce, otp_pgm} !== 2'b11) begin
      bad++; $display("[TB] FAIL pgm_cycle5 got ce=%b pgm=%b exp 11", otp_ce, otp_pgm);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({otp_ce, otp_pgm, otp_addr, otp_wdata, f_rsp_valid, i_rsp_valid, f_cmd_ready, i_cmd_ready} !== '0) begin
      bad++; $display("[TB] FAIL async_reset got ce=%b pgm=%b addr=%h exp all 0", otp_ce, otp_pgm, otp_addr);
    end
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    i_cmd_valid = 1; i_cmd_read = 1; i_cmd_addr = 32'h44;
    f_cmd_valid = 1; f_cmd_read = 1; f_cmd_addr = 32'h40;
    #1;
    total++;
    if ({f_cmd_ready, i_cmd_ready} !== 2'b10) begin
      bad++; $display("[TB] FAIL tie_after_reset got=%b%b exp=10", f_cmd_ready, i_cmd_ready);
    end
    sendCmd(PORT_F, 32'h40, 1'b1, 32'h0, '{PORT_F, mem[16], 1'b0, RDL + 1}, hs, ok);
    i_cmd_valid = 0;
    if (ok) waitRsp(PORT_F, hs, RDL, 0, 10'd16, 32'h0, 0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hC0DE_0000 | i;
    mem[4] = 32'hDEAD_BEEF;
    @(negedge clk);
    test_reset();
    test_read_f();
    test_pgm_i();
    test_write_f();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout got=running exp=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/sirv_otp_ctrl.md
# sirv_otp_ctrl

Controller and arbiter for the single OTP macro behind the OTP peripheral's two ICB slave ports. The fetch port (`f_icb`, execute-in-place reads) and the register port (`i_icb`, reads plus word programming) are arbitrated round-robin onto one macro interface. The controller sequences fixed-latency reads and timed program pulses, then returns one response per command to the owning port. It sits between the ICB fabric and the OTP hard macro (or its FPGA model).

## Interface
- `OTP_AW`, 10: OTP word-address width; macro holds 2^OTP_AW 32-bit words.
- `RD_LAT`, 2: cycles `otp_ce` is held per read; legal values are ≥1.
- `PGM_CYC`, 16: cycles `otp_pgm` is held per program; legal values are ≥1.
- `clk` in 1: sole clock.
- `rst` in 1: asynchronous, active-high reset.
- `f_icb_cmd_valid` in 1, `f_icb_cmd_ready` out 1, `f_icb_cmd_addr` in 32, `f_icb_cmd_read` in 1, `f_icb_cmd_wdata` in 32: fetch-port command.
- `f_icb_rsp_valid` out 1, `f_icb_rsp_ready` in 1, `f_icb_rsp_rdata` out 32, `f_icb_rsp_err` out 1: fetch-port response.
- `i_icb_cmd_*` and `i_icb_rsp_*`: same set and widths as `f_icb`; register port.
- `otp_ce` out 1: macro chip enable.
- `otp_pgm` out 1: program strobe.
- `otp_addr` out OTP_AW: word address.
- `otp_wdata` out 32: program data.
- `otp_rdata` in 32: macro read data, valid at the end of the RD_LAT-th `otp_ce` cycle.

## Operation
- FSM states: IDLE, READ, PGM, RSP.
- Only one command is in flight at a time.
- `x_icb_cmd_ready` = (state==IDLE) & grant_x. It is combinational and never asserted for the non-granted port.
- Arbitration (in IDLE):
  - One port valid: that port is granted.
  - Both ports valid: grant the port not granted last.
  - `last` updates on each accepted command. Reset value is `last`=i, so the first tie goes to f.
- On cmd handshake, latch owner, `addr[OTP_AW+1:2]`, wdata and read. Bits [1:0] and bits above OTP_AW+1 are ignored (decoded upstream).
- Next state after accept:
  - Read: READ, counter=RD_LAT-1.
  - Write from i: PGM, counter=PGM_CYC-1.
  - Write from f: RSP with err=1 and rdata=0; no macro access.
- READ: `otp_ce`=1 and `otp_addr` are stable. Decrement the counter each cycle. On counter==0, capture `otp_rdata` into the rsp register and go to RSP with err=0.
- PGM: `otp_ce`=1 and `otp_pgm`=1; `otp_addr` and `otp_wdata` are stable for exactly PGM_CYC cycles. Then go to RSP with rdata=0 and err=0.
- RSP: owner's `rsp_valid`=1 and the other port's is 0. `rdata`/`err` are held stable until `rsp_ready`. On handshake go to IDLE; no command is accepted in that same cycle.
- Macro outputs are 0 in IDLE and RSP.

## Timing
- Reset values: every output is 0; state=IDLE; `last`=i.
- Reset asserted mid-operation: `otp_ce`/`otp_pgm` drop immediately (asynchronous). The pending response is discarded. Requesters are reset together with this block.
- Read: cmd handshake at cycle 0 → `otp_ce` high for cycles 1..RD_LAT → `rsp_valid` from cycle RD_LAT+1. Default latency is 3.
- Program: `otp_pgm` high for cycles 1..PGM_CYC → `rsp_valid` at cycle PGM_CYC+1.
- f-port write error: `rsp_valid` at cycle 1.
- Response stall: RSP is held indefinitely; neither port gets cmd_ready.
- Back-to-back: next command handshake occurs no earlier than one cycle after the rsp handshake.
- A requester may drop `cmd_valid` without a handshake. The grant is recomputed every IDLE cycle, and `last` changes only on handshake.

## Structure
- Shared package `sirv_otp_pkg`:
  - FSM state encodings (2-bit).
  - Default RD_LAT and PGM_CYC.
  - Port-ID constants F=0, I=1.
- Sub-module `sirv_otp_rr_arb`: 2-way round-robin arbiter.
  - Inputs: req[1:0], accept, clk, rst.
  - Output: one-hot grant.
  - Owns the `last` flop.
- Counter, FSM, capture registers and response mux live in `sirv_otp_ctrl`.

## Test plan
- Read from f at addr 0x0000_0010, model returns 0xDEAD_BEEF → `otp_addr`=4, `otp_ce` high 2 cycles, `f_icb_rsp_valid` at cycle 3 with rdata 0xDEAD_BEEF, err=0; `i_icb_rsp_valid` stays 0.
- Write 0x1234_5678 to 0x0000_0020 via i → `otp_pgm` high exactly 16 cycles, `otp_addr`=8, `otp_wdata`=0x1234_5678, response err=0 at cycle 17.
- Write via f → no `otp_ce`, `f_icb_rsp_err`=1 and rdata=0 at cycle 1.
- Both ports valid continuously with reads, rsp_ready=1 → grants alternate f,i,f,i from reset; each response goes only to its owner.
- Read with rsp_ready held 0 for 10 cycles → rsp held stable, both cmd_ready=0, then completes on ready; next cmd is accepted ≥1 cycle later.
- Assert rst during PGM cycle 5 → `otp_pgm`/`otp_ce` fall in the same cycle, all outputs 0. After release, a read completes normally and f wins the first tie.
